// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 10/1 yuan change payout sequencer with 4-phase hopper handshake
module change_dispenser #(
   parameter int TEN_INIT    = 10,
   parameter int ONE_INIT    = 20,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [7:0] value,
   input  logic       clr,
   input  logic       refill,
   input  logic       ten_ack,
   input  logic       one_ack,
   output logic       drop_ten,
   output logic       drop_one,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] short_amt,
   output logic [7:0] ten_left,
   output logic [7:0] one_left
);

   // counter only has to reach ACK_TIMEOUT-1; the last waiting cycle triggers the jam
   localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, SEL, DROP_T, DROP_O, REL, DONE_S, ERR
   } state_t;

   state_t        state;
   logic [7:0]    remaining;
   logic [CW-1:0] cnt;

   // single FSM: every output is a register updated together with the state transition
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         remaining <= 8'd0;
         cnt       <= '0;
         drop_ten  <= 1'b0;
         drop_one  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
         short_amt <= 8'd0;
         ten_left  <= 8'(TEN_INIT);
         one_left  <= 8'(ONE_INIT);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  remaining <= value;
                  busy      <= 1'b1;
                  state     <= SEL;
               end else if (refill) begin
                  ten_left <= 8'(TEN_INIT);
                  one_left <= 8'(ONE_INIT);
               end
            end
            SEL: begin
               // greedy: tens first, ones also cover a large remainder once tens run out
               if (remaining == 8'd0) begin
                  done  <= 1'b1;
                  state <= DONE_S;
               end else if (remaining >= 8'd10 && ten_left != 8'd0) begin
                  drop_ten <= 1'b1;
                  cnt      <= '0;
                  state    <= DROP_T;
               end else if (one_left != 8'd0) begin
                  drop_one <= 1'b1;
                  cnt      <= '0;
                  state    <= DROP_O;
               end else begin
                  err       <= 1'b1;
                  err_code  <= 2'b01;
                  short_amt <= remaining;
                  state     <= ERR;
               end
            end
            DROP_T: begin
               if (ten_ack) begin
                  remaining <= remaining - 8'd10;
                  ten_left  <= ten_left - 8'd1;
                  drop_ten  <= 1'b0;
                  state     <= REL;
               end else if (cnt == CNT_LAST) begin
                  drop_ten  <= 1'b0;
                  err       <= 1'b1;
                  err_code  <= 2'b10;
                  short_amt <= remaining;
                  state     <= ERR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DROP_O: begin
               if (one_ack) begin
                  remaining <= remaining - 8'd1;
                  one_left  <= one_left - 8'd1;
                  drop_one  <= 1'b0;
                  state     <= REL;
               end else if (cnt == CNT_LAST) begin
                  drop_one  <= 1'b0;
                  err       <= 1'b1;
                  err_code  <= 2'b10;
                  short_amt <= remaining;
                  state     <= ERR;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            REL: begin
               // wait for the hopper to release its ack before asking for the next coin
               if (!ten_ack && !one_ack) begin
                  state <= SEL;
               end
            end
            DONE_S: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERR: begin
               if (clr) begin
                  err       <= 1'b0;
                  err_code  <= 2'b00;
                  short_amt <= 8'd0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               drop_ten <= 1'b0;
               drop_one <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized scoreboard bench for change_dispenser
module tb_change_dispenser;

   localparam int TEN_INIT    = 10;
   localparam int ONE_INIT    = 20;
   localparam int ACK_TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst, req, clr, refill, ten_ack, one_ack;
   logic [7:0] value;
   logic       drop_ten, drop_one, busy, done, err;
   logic [1:0] err_code;
   logic [7:0] short_amt, ten_left, one_left;

   typedef struct {
      bit         is_err;
      logic [1:0] code;
      logic [7:0] short_amt;
      logic [7:0] ten;
      logic [7:0] one;
      int         n_ten;
      int         n_one;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t stim_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_ten, m_one;
   bit   jam;
   bit   hop_ten;

   change_dispenser #(
      .TEN_INIT(TEN_INIT), .ONE_INIT(ONE_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .value(value), .clr(clr), .refill(refill),
      .ten_ack(ten_ack), .one_ack(one_ack), .drop_ten(drop_ten), .drop_one(drop_one),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .short_amt(short_amt),
      .ten_left(ten_left), .one_left(one_left)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // reference: greedy payout from the current hopper contents, or a jam on the first coin
   function automatic exp_t model(input int v);
      exp_t e;
      int   rem, tu, ou;
      e.is_err = 0; e.code = 2'b00; e.short_amt = 8'd0; e.n_ten = 0; e.n_one = 0;
      if (jam && v != 0 && ((v >= 10 && m_ten > 0) || m_one > 0)) begin
         e.is_err = 1; e.code = 2'b10; e.short_amt = 8'(v);
         if (v >= 10 && m_ten > 0) e.n_ten = 1;
         else e.n_one = 1;
         e.ten = 8'(m_ten); e.one = 8'(m_one);
      end else begin
         tu  = (v / 10 < m_ten) ? v / 10 : m_ten;
         rem = v - 10 * tu;
         ou  = (rem < m_one) ? rem : m_one;
         rem = rem - ou;
         e.n_ten = tu; e.n_one = ou;
         e.ten = 8'(m_ten - tu); e.one = 8'(m_one - ou);
         if (rem != 0) begin
            e.is_err = 1; e.code = 2'b01; e.short_amt = 8'(rem);
         end
      end
      return e;
   endfunction

   // hopper model: ack after 0..3 cycles, hold until drop falls, release after 0..2 cycles
   initial begin
      ten_ack = 1'b0;
      one_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && !jam && (drop_ten || drop_one)) begin
            hop_ten = drop_ten;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (hop_ten) ten_ack = 1'b1;
            else one_ack = 1'b1;
            for (int i = 0; i < 20 && (drop_ten || drop_one); i++) @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ten_ack = 1'b0;
            one_ack = 1'b0;
         end
      end
   end

   int   cur_ten, cur_one, run, last_run;
   logic prev_ten, prev_one, prev_err;
   bit   chk_busy;

   // monitor: counts drop handshakes and scores each done/err against the queue
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         cur_ten = 0; cur_one = 0; run = 0; last_run = 0;
         prev_ten = 0; prev_one = 0; prev_err = 0; chk_busy = 0;
      end else begin
         if (chk_busy) begin
            check("busy_after_done", busy, 0);
            chk_busy = 0;
         end
         if (drop_ten || drop_one) begin
            check("drop_exclusive", int'(drop_ten & drop_one), 0);
            check("drop_while_busy", busy, 1);
         end
         if (drop_ten && !prev_ten) cur_ten++;
         if (drop_one && !prev_one) cur_one++;
         if (drop_ten || drop_one) run++;
         else if (run != 0) begin
            last_run = run;
            run = 0;
         end
         if (done || (err && !prev_err)) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_response: got done=%0d err=%0d expected no response", done, err);
            end else begin
               mon_e = exp_q.pop_front();
               check("resp_is_err", err, int'(mon_e.is_err));
               check("resp_done", done, int'(!mon_e.is_err));
               check("err_code", err_code, mon_e.code);
               check("short_amt", short_amt, mon_e.short_amt);
               check("ten_left", ten_left, mon_e.ten);
               check("one_left", one_left, mon_e.one);
               check("ten_drops", cur_ten, mon_e.n_ten);
               check("one_drops", cur_one, mon_e.n_one);
               if (!mon_e.is_err) chk_busy = 1;
               if (mon_e.code == 2'b10) check("jam_drop_cycles", last_run, ACK_TIMEOUT);
            end
            cur_ten = 0; cur_one = 0;
         end
         prev_ten = drop_ten; prev_one = drop_one; prev_err = err;
      end
   end

   task automatic do_refill();
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      m_ten = TEN_INIT;
      m_one = ONE_INIT;
   endtask

   task automatic wait_end();
      int waited = 0;
      while (!(err || !busy) && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      check("payout_finishes", int'(err || !busy), 1);
      if (err) begin
         repeat ($urandom_range(1, 3)) @(negedge clk);
         req = 1'b1; refill = 1'b1; value = 8'd5;
         @(negedge clk);
         req = 1'b0; refill = 1'b0;
         @(negedge clk);
         check("err_held", err, 1);
         check("err_ten_kept", ten_left, m_ten);
         check("err_one_kept", one_left, m_one);
         clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
         check("clr_err", err, 0);
         check("clr_err_code", err_code, 0);
         check("clr_short_amt", short_amt, 0);
         check("clr_busy", busy, 0);
      end
   endtask

   task automatic issue(input int v, input bit with_refill, input bit poke);
      stim_e = model(v);
      exp_q.push_back(stim_e);
      m_ten = stim_e.ten;
      m_one = stim_e.one;
      req = 1'b1; value = 8'(v); refill = with_refill;
      @(negedge clk);
      req = 1'b0; refill = 1'b0;
      if (poke) begin
         req = 1'b1; refill = 1'b1; value = 8'($urandom_range(0, 255));
         @(negedge clk);
         req = 1'b0; refill = 1'b0;
      end
      wait_end();
   endtask

   // watchdog so a stuck design cannot hang the run
   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

   // stimulus sequence: directed corner cases wrapped around a randomized payout loop
   initial begin
      rst = 1'b0; req = 1'b0; clr = 1'b0; refill = 1'b0; value = 8'd0; jam = 0;
      m_ten = TEN_INIT; m_one = ONE_INIT;
      repeat (2) @(negedge clk);
      check("rst_ten_left", ten_left, TEN_INIT);
      check("rst_one_left", one_left, ONE_INIT);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_short_amt", short_amt, 0);
      check("rst_drops", int'(drop_ten | drop_one), 0);
      rst = 1'b1;
      @(negedge clk);

      issue(23, 0, 0);

      stim_e = model(0);
      exp_q.push_back(stim_e);
      req = 1'b1; value = 8'd0;
      @(negedge clk);
      req = 1'b0;
      check("zero_done_n1", done, 0);
      @(negedge clk);
      check("zero_done_n2", done, 1);
      check("zero_no_drop", int'(drop_ten | drop_one), 0);
      @(negedge clk);
      check("zero_done_n3", done, 0);
      check("zero_idle", busy, 0);

      do_refill();
      check("refill_ten", ten_left, TEN_INIT);
      check("refill_one", one_left, ONE_INIT);
      issue(80, 0, 0);
      issue(45, 0, 1);

      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 4) == 0) do_refill();
         jam = ($urandom_range(0, 9) == 0);
         issue(int'($urandom_range(0, 80)), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
         jam = 0;
      end

      do_refill();
      jam = 1;
      issue(10, 0, 0);
      issue(5, 0, 0);
      jam = 0;

      do_refill();
      jam = 1;
      req = 1'b1; value = 8'd3;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      check("drop_one_before_reset", drop_one, 1);
      #2 rst = 1'b0;
      #1;
      check("reset_drop_one", drop_one, 0);
      check("reset_busy", busy, 0);
      check("reset_ten_left", ten_left, TEN_INIT);
      check("reset_one_left", one_left, ONE_INIT);
      repeat (2) @(negedge clk);
      rst = 1'b1; jam = 0;
      m_ten = TEN_INIT; m_one = ONE_INIT;
      @(negedge clk);
      issue(15, 0, 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences the refund/change output of the vending machine.
- Takes a single change request (amount in yuan) from the machine controller and drives the 10-yuan and 1-yuan coin hoppers one coin at a time, greedy 10-first, with a 4-phase drop/ack handshake per coin.
- Tracks the coins left in each hopper and reports completion, shortfall or hopper jam back to the controller.

Parameters:
TEN_INIT, 10, 10-yuan coins loaded at reset/refill (0..255)
ONE_INIT, 20, 1-yuan coins loaded at reset/refill (0..255)
ACK_TIMEOUT, 1000, max cycles drop_* may stay high without ack before jam error (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  1  change request, sampled only in IDLE
value  in  8  change amount in yuan, latched with req
clr  in  1  clears ERR state back to IDLE
refill  in  1  reload hopper counts to *_INIT, honoured only in IDLE
ten_ack  in  1  10-yuan hopper ack (coin released)
one_ack  in  1  1-yuan hopper ack
drop_ten  out  1  request one 10-yuan coin
drop_one  out  1  request one 1-yuan coin
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: change fully paid
err  out  1  high while in ERR
err_code  out  2  00 none, 01 insufficient coins, 10 hopper jam; valid while err
short_amt  out  8  unpaid remainder, valid while err, else 0
ten_left  out  8  10-yuan coins remaining
one_left  out  8  1-yuan coins remaining

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except ten_left=TEN_INIT, one_left=ONE_INIT; remaining register and timeout counter cleared. Reset mid-drop drops drop_* immediately; the partial payout is abandoned.
- All outputs registered/decoded from registered state; no combinational input-to-output path.
- States: IDLE, SEL, DROP_T, DROP_O, REL, DONE, ERR.
- IDLE:
  - req=1 latches value into remaining (8 bit) and goes to SEL.
  - refill=1 with req=0 reloads both counts.
  - req and refill in the same cycle: req wins, refill ignored.
- SEL, priority order:
  - remaining==0 -> DONE.
  - remaining>=10 and ten_left>0 -> DROP_T.
  - remaining>0 and one_left>0 -> DROP_O. This covers remaining>=10 with tens exhausted.
  - Otherwise -> ERR, err_code=01, short_amt=remaining.
- DROP_T / DROP_O:
  - drop_ten / drop_one high for the whole state; the timeout counter runs from 0.
  - The matching ack sampled high (including in the first cycle) decrements remaining by 10 or 1, decrements the hopper count, and goes to REL.
  - The counter reaching ACK_TIMEOUT with no ack -> ERR, err_code=10, short_amt=remaining; the count is not decremented.
  - Acks from the non-selected hopper are ignored.
- REL: drop_* low; wait for both acks low (4-phase completion), then SEL. No timeout in REL.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- ERR: err=1 and busy=1, held until clr=1, which goes to IDLE and zeroes err_code and short_amt. req and refill are ignored in ERR.
- Requests while busy are ignored; value is not re-sampled.
- Latency:
  - req at cycle N -> SEL at N+1 -> drop_* high at N+2.
  - value=0 gives a done pulse at N+2.
  - Each coin costs at minimum 3 cycles: DROP with same-cycle ack, REL, SEL.
- Counts never wrap: decrements occur only when the count is >0 (guaranteed by SEL).
- At most one drop_* is high at any time, and drop_* is never high outside DROP_T/DROP_O.

Test Plan:
- Normal payout: defaults, value=23, hopper acks 1 cycle after drop, released 1 cycle later -> exactly 2 drop_ten then 3 drop_one handshakes, one done pulse, ten_left=8, one_left=17, busy low after done.
- Zero value: req with value=0 at cycle N -> done=1 at N+2 only, no drop_* activity, counts unchanged.
- Ten hopper exhausted: TEN_INIT=1, value=25 -> 1 ten drop then 15 one drops, done, ten_left=0, one_left=5.
- Insufficient coins: TEN_INIT=0, ONE_INIT=3, value=5 -> 3 one drops, then err=1, err_code=01, short_amt=2, one_left=0; clr -> IDLE with err=0.
- Jam: value=10, ten_ack held 0 -> drop_ten high for ACK_TIMEOUT cycles, then err_code=10, short_amt=10, ten_left unchanged; req during ERR ignored.
- Reset/refill: rst=0 asserted mid DROP_O -> drop_one low immediately, counts=INIT. refill in IDLE after a payout restores counts; refill while busy has no effect.
